key_scan_ctrl: RTL and testbench

Matrix-keypad scan controller that sequences row drive, samples columns and debounces every key with one shared scan-rate stability counter instead of one debouncer per key. It sits between the board keypad pins and the application logic. It emits one key event at a time on a valid/ready output. It replaces per-key debouncer instances when more than a handful of keys exist.

---
 rtl/key_scan_pkg.sv | 23 ++
 rtl/key_scan_timer.sv | 26 ++
 rtl/key_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the keypad scan controller.
package key_scan_pkg;

  typedef enum logic [1:0] {DRIVE, SAMPLE, COMPARE, EMIT} state_t;

  // Upper bound on ROWS*COLS handled by the priority encoder.
  localparam int MAX_KEYS = 256;

  // Width of a key index for n_keys keys.
  function automatic int code_width(input int n_keys);
    return (n_keys <= 2) ? 1 : $clog2(n_keys);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [7:0] lsb_index(input logic [MAX_KEYS-1:0] v);
    logic [7:0] idx;
    idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--)
      if (v[i]) idx = 8'(i);
    return idx;
  endfunction

endpackage

// File: rtl/key_scan_timer.sv
// Loadable down-counter; done while the count sits at zero.
// Used for row settle time and, inside EMIT, for the stall timeout.
module key_scan_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= RST_VAL;
    else if (load)             cnt <= val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/key_scan_ctrl.sv
// Matrix keypad scanner with one shared stability counter for the whole
// key map. Emits one press (and optionally release) event at a time on a
// valid/ready port.
// Build option: KEY_SCAN_RELEASE_EN -- when defined, releases are emitted as
// events; otherwise releases are absorbed silently and key_release_o is 0.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter  int ROWS         = 4,
  parameter  int COLS         = 4,
  parameter  int SCAN_DIV     = 1000,
  parameter  int STABLE_SCANS = 4,
  localparam int CW           = code_width(ROWS * COLS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [COLS-1:0] col_i,
  output logic [ROWS-1:0] row_o,
  output logic [CW-1:0]   key_code_o,
  output logic            key_release_o,
  output logic            key_valid_o,
  input  logic            key_ready_i,
  output logic            overrun_o
);

  localparam int NK        = ROWS * COLS;
  localparam int RW        = (ROWS <= 2) ? 1 : $clog2(ROWS);
  localparam int SW        = $clog2(STABLE_SCANS + 1);
  localparam int STALL_LIM = 2 * ROWS * (SCAN_DIV + 1);
  localparam int TW        = $clog2(STALL_LIM + 1);

  localparam logic [TW-1:0]   DIV_LD   = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0]   STALL_LD = TW'(STALL_LIM);
  localparam logic [SW-1:0]   CNT_MAX  = SW'(STABLE_SCANS);
  localparam logic [ROWS-1:0] ROW0     = ROWS'(1);

  state_t                     state, state_nxt;
  logic [RW-1:0]              row, row_nxt;
  logic [SW-1:0]              cnt, cnt_nxt;
  logic [ROWS-1:0][COLS-1:0]  snap;
  logic [NK-1:0]              snap_flat, prev, deb, diff;
  logic [MAX_KEYS-1:0]        diff_ext;
  logic [CW-1:0]              idx;
  logic                       any_diff, slot_free, stalled, load_evt, flip;
  logic                       t_load, t_en, t_done;
  logic [TW-1:0]              t_val;

  assign snap_flat = snap;
  assign diff      = snap_flat ^ deb;
  assign any_diff  = |diff;
  assign slot_free = !key_valid_o || key_ready_i;
  assign stalled   = (state == EMIT) && key_valid_o && !key_ready_i;

  // Lowest-index key whose debounced state disagrees with the snapshot.
  always_comb begin
    diff_ext         = '0;
    diff_ext[NK-1:0] = diff;
    idx              = CW'(lsb_index(diff_ext));
  end

`ifdef KEY_SCAN_RELEASE_EN
  assign load_evt = (state == EMIT) && any_diff && slot_free;
  assign flip     = load_evt;
`else
  // Releases just flip the debounced bit; only presses need the slot.
  assign load_evt = (state == EMIT) && any_diff && !deb[idx] && slot_free;
  assign flip     = load_evt || ((state == EMIT) && any_diff && deb[idx]);
  assign key_release_o = 1'b0;
`endif

  key_scan_timer #(.W(TW), .RST_VAL(DIV_LD)) u_timer (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (t_load),
    .val  (t_val),
    .en   (t_en),
    .done (t_done)
  );

  // Next-state, row, stability count and timer control.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt;
    t_load    = 1'b0;
    t_val     = DIV_LD;
    t_en      = 1'b0;
    case (state)
      DRIVE: begin
        if (t_done) state_nxt = SAMPLE;
        else        t_en      = 1'b1;
      end
      SAMPLE: begin
        t_load = 1'b1;
        if (row == RW'(ROWS - 1)) begin
          state_nxt = COMPARE;
        end else begin
          row_nxt   = row + 1'b1;
          state_nxt = DRIVE;
        end
      end
      COMPARE: begin
        if (snap_flat == prev)
          cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        else
          cnt_nxt = SW'(1);
        row_nxt = '0;
        t_load  = 1'b1;
        if (cnt_nxt == CNT_MAX && any_diff) begin
          state_nxt = EMIT;
          t_val     = STALL_LD;
        end else begin
          state_nxt = DRIVE;
        end
      end
      EMIT: begin
        // Hold here until the map is caught up and the last event is taken,
        // so a stalled consumer also stalls scanning.
        if (!any_diff && slot_free) begin
          state_nxt = DRIVE;
          t_load    = 1'b1;
        end else if (stalled) begin
          t_en = 1'b1;
        end else begin
          t_load = 1'b1;
          t_val  = STALL_LD;
        end
      end
      default: state_nxt = DRIVE;
    endcase
  end

  // Scan state, key maps and row drive. row_o is registered from the next
  // state, so it reads 0 during reset and the first cycle after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= DRIVE;
      row   <= '0;
      cnt   <= '0;
      snap  <= '0;
      prev  <= '0;
      deb   <= '0;
      row_o <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      cnt   <= cnt_nxt;
      if (state == SAMPLE)  snap[row] <= col_i;
      if (state == COMPARE) prev      <= snap_flat;
      if (flip)             deb[idx]  <= ~deb[idx];
      row_o <= (state_nxt == DRIVE || state_nxt == SAMPLE) ? (ROW0 << row_nxt) : '0;
    end
  end

  // Event slot: a load may replace an event accepted in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_valid_o <= 1'b0;
      key_code_o  <= '0;
      overrun_o   <= 1'b0;
    end else begin
      if (load_evt) begin
        key_valid_o <= 1'b1;
        key_code_o  <= idx;
      end else if (key_ready_i) begin
        key_valid_o <= 1'b0;
      end
      if (stalled && t_done) overrun_o <= 1'b1;
    end
  end

`ifdef KEY_SCAN_RELEASE_EN
  // Release flag is the debounced bit before the flip.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         key_release_o <= 1'b0;
    else if (load_evt) key_release_o <= deb[idx];
  end
`endif

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: keypad model, event scoreboard, vector table and
// hand-written stall / bounce / reset sequences.
`timescale 1ns/1ps
module tb_key_scan_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CW   = 4;
`ifdef KEY_SCAN_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [COLS-1:0] col_i;
  logic [ROWS-1:0] row_o;
  logic [CW-1:0]   key_code_o;
  logic            key_release_o, key_valid_o, key_ready_i, overrun_o;
  logic [15:0]     keys;

  int total = 0, bad = 0, cyc = 0, last_evt = 0, prev_evt = 0;

  typedef struct { logic [3:0] code; logic rel; } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          n;
    logic [3:0]  c0, c1, c2;
    logic        rel;
  } vec_t;
  vec_t vt [6];

  always #5 clk_i = ~clk_i;

  key_scan_ctrl #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .STABLE_SCANS(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .col_i         (col_i),
    .row_o         (row_o),
    .key_code_o    (key_code_o),
    .key_release_o (key_release_o),
    .key_valid_o   (key_valid_o),
    .key_ready_i   (key_ready_i),
    .overrun_o     (overrun_o)
  );

  // Keypad: key k sits at row k/COLS, column k%COLS.
  always_comb begin
    col_i = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_o[r]) col_i = col_i | keys[r*COLS +: COLS];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic push(input logic [3:0] code, input logic rel);
    ev_t e;
    e.code = code;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] v, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (row_o != v && n < budget);
    if (row_o != v) timeout(name);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!key_valid_o && n < budget);
    if (!key_valid_o) timeout(name);
  endtask

  task automatic next_scan();
    wait_row(4'b0000, 40, "scan_end");
    wait_row(4'b0001, 40, "scan_start");
    tick();
  endtask

  // Scoreboard: every accepted event must match the head of the queue.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i && key_valid_o && key_ready_i) begin
      prev_evt = last_evt;
      last_evt = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got code=%0d rel=%0d want none", key_code_o, key_release_o);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_code", key_code_o, e.code);
        check("event_rel", key_release_o, e.rel);
      end
    end
  end

  int          errs, n, lat, rel_cyc, pushed;
  logic [3:0]  exp_row;

  initial begin
    vt[0] = '{16'h0040, 1, 4'd6, 4'd0,  4'd0,  1'b0};
    vt[1] = '{16'h0000, 1, 4'd6, 4'd0,  4'd0,  1'b1};
    vt[2] = '{16'h4002, 2, 4'd1, 4'd14, 4'd0,  1'b0};
    vt[3] = '{16'h4000, 1, 4'd1, 4'd0,  4'd0,  1'b1};
    vt[4] = '{16'hC001, 2, 4'd0, 4'd15, 4'd0,  1'b0};
    vt[5] = '{16'h0000, 3, 4'd0, 4'd14, 4'd15, 1'b1};

    keys        = '0;
    key_ready_i = 1'b1;
    rst_i       = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_row", row_o, 0);
    check("rst_code", key_code_o, 0);
    check("rst_rel", key_release_o, 0);
    check("rst_valid", key_valid_o, 0);
    check("rst_overrun", overrun_o, 0);
    tick();
    rst_i = 1'b0;

    // Idle: regular row walk, no events.
    wait_row(4'b0001, 50, "first_row");
    wait_row(4'b0000, 50, "first_compare");
    for (int s = 0; s < 10; s++) begin
      errs = 0;
      for (int i = 0; i < 21; i++) begin
        @(negedge clk_i);
        exp_row = (i < 20) ? 4'(1 << (i / 5)) : 4'b0000;
        if (row_o !== exp_row || key_valid_o !== 1'b0) errs++;
      end
      check($sformatf("idle_scan%0d_errs", s), errs, 0);
    end

    // Vector table with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      tick();
      keys   = vt[v].keys;
      pushed = 0;
      if (!vt[v].rel || REL_EN) begin
        pushed = vt[v].n;
        if (vt[v].n > 0) push(vt[v].c0, vt[v].rel);
        if (vt[v].n > 1) push(vt[v].c1, vt[v].rel);
        if (vt[v].n > 2) push(vt[v].c2, vt[v].rel);
      end
      repeat (130) @(negedge clk_i);
      check($sformatf("vec%0d_pending", v), exp_q.size(), 0);
      if (pushed > 1) check($sformatf("vec%0d_b2b", v), last_evt - prev_evt, 1);
    end

    // Bounce: key 6 toggles every scan, then settles pressed.
    for (int t = 0; t < 8; t++) begin
      next_scan();
      keys = (t % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    next_scan();
    keys = 16'h0040;
    push(4'd6, 1'b0);
    repeat (130) @(negedge clk_i);
    check("bounce_pending", exp_q.size(), 0);

    // Stall: consumer not ready while key 5 is pressed.
    tick();
    keys        = 16'h0060;
    key_ready_i = 1'b0;
    push(4'd5, 1'b0);
    wait_valid(200, "stall_valid");
    errs = 0;
    for (int s = 1; s <= 45; s++) begin
      if (s > 1) @(negedge clk_i);
      if (key_valid_o !== 1'b1 || key_code_o !== 4'd5 ||
          key_release_o !== 1'b0 || row_o !== 4'b0000) errs++;
      if (s == 40) check("overrun_early", overrun_o, 0);
    end
    check("stall_hold_errs", errs, 0);
    check("overrun_set", overrun_o, 1);
    tick();
    key_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("resume_row0", row_o, 1);
    repeat (130) @(negedge clk_i);
    check("stall_pending", exp_q.size(), 0);
    check("overrun_sticky", overrun_o, 1);

    // Reset while an event is pending in EMIT.
    tick();
    key_ready_i = 1'b0;
    keys        = 16'h0260;
    wait_valid(200, "pre_reset_valid");
    check("pre_reset_code", key_code_o, 9);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_row", row_o, 0);
    check("mid_rst_code", key_code_o, 0);
    check("mid_rst_valid", key_valid_o, 0);
    check("mid_rst_overrun", overrun_o, 0);
    check("mid_rst_rel", key_release_o, 0);
    repeat (2) @(negedge clk_i);
    tick();
    rst_i       = 1'b0;
    key_ready_i = 1'b1;
    rel_cyc     = cyc;
    push(4'd5, 1'b0);
    push(4'd6, 1'b0);
    push(4'd9, 1'b0);
    n = 0;
    while (exp_q.size() == 3 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() == 3) timeout("reemit");
    else begin
      lat = cyc - rel_cyc;
      total++;
      if (lat < 55 || lat > 75) begin
        bad++;
        $display("FAIL reemit_latency: got %0d want 55..75", lat);
      end
    end
    repeat (40) @(negedge clk_i);
    check("reemit_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
